ram_port_ctrl: RTL

//  Initiator side of one synchronous port of the inferred dual-port RAM. Turns a

---
 rtl/ram_port_ctrl_if.sv | 25 ++
 rtl/ram_port_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ram_port_ctrl_if.sv
// Request/response streams between a RAM port controller and its initiator.
// master = the initiator issuing requests and consuming read data; slave = the controller.
interface ram_port_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_port_ctrl.sv
// Initiator side of one synchronous RAM port: clears the array, then maps a request
// stream onto we/addr/di and returns read data through a credit-limited FWFT FIFO.
module ram_port_ctrl #(
    parameter int            AW        = 4,
    parameter int            DW        = 4,
    parameter logic [DW-1:0] INIT_VAL  = '0,
    parameter int            RSP_DEPTH = 2
) (
    input  logic              i_clk1,
    input  logic              i_rst_n,
    input  logic              i_clr_start,
    output logic              o_init_done,
    ram_port_ctrl_if.slave    io_bus,
    output logic              o_ram_we,
    output logic [AW-1:0]     o_ram_addr,
    output logic [DW-1:0]     o_ram_di,
    input  logic [DW-1:0]     i_ram_do
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int OW = $clog2(RSP_DEPTH + 3);

    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_ptr;
    logic          r_init_done;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_di;
    logic [1:0]    r_rd_pipe;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [DW-1:0] r_fifo_mem [RSP_DEPTH];
    logic [DW-1:0] r_last_rdata;

    logic [OW-1:0] w_outstanding;
    logic          w_req_ready;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_rsp_valid;
    logic [DW-1:0] w_head;

    // Reads in flight count against the FIFO so a granted read always has a slot.
    assign w_outstanding = OW'(r_count) + OW'(r_rd_pipe[0]) + OW'(r_rd_pipe[1]);
    assign w_req_ready   = (r_state == ST_RUN) && !i_clr_start
                           && (w_outstanding < OW'(RSP_DEPTH));
    assign w_accept      = io_bus.req_valid && w_req_ready;
    assign w_push        = r_rd_pipe[1];
    assign w_rsp_valid   = (r_count != '0);
    assign w_pop         = w_rsp_valid && io_bus.rsp_ready;
    assign w_head        = r_fifo_mem[r_rd_ptr];

    assign io_bus.req_ready = w_req_ready;
    assign io_bus.rsp_valid = w_rsp_valid;
    assign io_bus.rsp_rdata = w_rsp_valid ? w_head : r_last_rdata;
    assign o_init_done      = r_init_done;
    assign o_ram_we         = r_ram_we;
    assign o_ram_addr       = r_ram_addr;
    assign o_ram_di         = r_ram_di;

    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_ptr   <= '0;
            r_init_done <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_di    <= '0;
            r_rd_pipe   <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_accept && !io_bus.req_we};
            case (r_state)
                ST_CLEAR: begin
                    r_ram_we   <= 1'b1;
                    r_ram_addr <= r_clr_ptr;
                    r_ram_di   <= INIT_VAL;
                    r_clr_ptr  <= r_clr_ptr + AW'(1);
                    if (r_clr_ptr == '1) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_ram_we <= w_accept && io_bus.req_we;
                    if (w_accept) begin
                        r_ram_addr <= io_bus.req_addr;
                        r_ram_di   <= io_bus.req_wdata;
                    end
                    if (i_clr_start) begin
                        r_state     <= ST_CLEAR;
                        r_clr_ptr   <= '0;
                        r_init_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    // FIFO bookkeeping; rsp_rdata falls back to the last popped word when empty.
    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_rdata <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= (r_rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
                r_last_rdata <= w_head;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_slot
            always_ff @(posedge i_clk1 or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_fifo_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_fifo_mem[gi] <= i_ram_do;
                end
            end
        end
    endgenerate
endmodule
